// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: MMIO register map, STATUS layout and RAM region helpers
// shared by the data-memory responder and its move FIFO.
package dmem_map_pkg;

  localparam logic [31:0] MMIO_STATUS    = 32'h0000_F000;
  localparam logic [31:0] MMIO_MOVE_DATA = 32'h0000_F001;
  localparam logic [31:0] MMIO_MOVE_POP  = 32'h0000_F002;
  localparam logic [31:0] MMIO_DISPLAY   = 32'h0000_F003;
  localparam logic [31:0] MMIO_CYCLE     = 32'h0000_F004;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [31:0] RAM_MASK_12 = 32'hFFFF_F000;

  function automatic logic [31:0] ram_mask(input int aw);
    ram_mask = ~((32'd1 << aw) - 32'd1);
  endfunction

  // count field saturates so deep FIFOs still fit in four bits
  function automatic logic [31:0] status_word(
    input logic        not_empty,
    input logic        full,
    input logic [31:0] cnt
  );
    logic [3:0] c4;
    c4 = (cnt > 32'd15) ? 4'd15 : cnt[3:0];
    status_word = '0;
    status_word[ST_NOT_EMPTY] = not_empty;
    status_word[ST_FULL] = full;
    status_word[ST_COUNT_LSB +: 4] = c4;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: small synchronous FIFO for UI moves, valid/ready push,
// pop strobe, zero head when empty, async active-low reset.
module move_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full       = count == CW'(DEPTH);
  assign empty      = count == '0;
  assign push_ready = rst_n & ~full;
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & ~empty;
  assign head       = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: word RAM plus MMIO window (DISPLAY, CYCLE) on dmem.
// Define MMIO_MOVE_FIFO_EN to add the move FIFO, STATUS, MOVE_DATA, MOVE_POP.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int MOVE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_dmem,
  input  logic [31:0]           data,
  input  logic                  wren,
  output logic [31:0]           q_dmem,
  input  logic                  move_valid,
  input  logic [MOVE_WIDTH-1:0] move_data,
  output logic                  move_ready,
  output logic [31:0]           display_out
);
  localparam int RAM_WORDS = 1 << ADDR_WIDTH;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycle_q;
  logic [31:0] status_w;
  logic [31:0] move_w;
  logic [31:0] rd_data;
  logic        mmio_sel;
  logic        ram_hit;
  logic        is_status;
  logic        is_move;
  logic        is_disp;
  logic        is_cycle;

  assign is_status = address_dmem == MMIO_STATUS;
  assign is_move   = address_dmem == MMIO_MOVE_DATA;
  assign is_disp   = address_dmem == MMIO_DISPLAY;
  assign is_cycle  = address_dmem == MMIO_CYCLE;
  assign mmio_sel  = is_status | is_move | is_disp | is_cycle;
  assign ram_hit   = ((address_dmem & ram_mask(ADDR_WIDTH)) == '0) & ~mmio_sel;

`ifdef MMIO_MOVE_FIFO_EN
  logic                  pop_req;
  logic                  pop_q;
  logic                  pop_fire;
  logic [MOVE_WIDTH-1:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // a stalled store holds wren high; only its first cycle pops
  assign pop_req  = wren && (address_dmem == MMIO_MOVE_POP);
  assign pop_fire = pop_req & ~pop_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pop_q <= 1'b0;
    else        pop_q <= pop_req;
  end

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MOVE_WIDTH)
  ) u_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .push_valid (move_valid),
    .push_data  (move_data),
    .push_ready (move_ready),
    .pop        (pop_fire),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign status_w = status_word(~fifo_empty, fifo_full, 32'(fifo_count));
  assign move_w   = 32'(fifo_head);
`else
  localparam int UNUSED_DEPTH = FIFO_DEPTH;
  logic unused_move;

  assign unused_move = ^{move_valid, move_data};
  assign move_ready  = 1'b0;
  assign status_w    = '0;
  assign move_w      = '0;
`endif

  always_ff @(posedge clock) begin
    if (wren && ram_hit) ram[address_dmem[ADDR_WIDTH-1:0]] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display_out <= '0;
      cycle_q     <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wren && is_disp) display_out <= data;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_status: rd_data = status_w;
      is_move:   rd_data = move_w;
      is_disp:   rd_data = display_out;
      is_cycle:  rd_data = cycle_q;
      ram_hit:   rd_data = ram[address_dmem[ADDR_WIDTH-1:0]];
      default:   ;
    endcase
  end

  // falling-edge capture so the processor sees it at the next rising edge
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) q_dmem <= '0;
    else        q_dmem <= rd_data;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder for the processor's data-memory port: it answers `address_dmem` / `data` / `wren` with `q_dmem`. Word-addressed RAM sits in the low region and a small MMIO window sits in the high region. The MMIO window carries a move FIFO fed by the checkers UI/input logic, a display register, and a cycle counter. The block sits in the wrapper between the processor and the board/UI logic, in place of a bare dmem.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, RAM word-address bits (4096 words).
- `FIFO_DEPTH`, 8, move FIFO entries; power of two, at least 2.
- `MOVE_WIDTH`, 16, move word width; zero-extended to 32 bits on read.

Ports:
- `clock`  in  1  master clock; the same clock as the processor.
- `reset`  in  1  asynchronous, active-low reset.
- `address_dmem`  in  32  word address from the processor.
- `data`  in  32  store data.
- `wren`  in  1  store enable.
- `q_dmem`  out  32  read data to the processor.
- `move_valid`  in  1  UI offers a move.
- `move_data`  in  MOVE_WIDTH  move payload.
- `move_ready`  out  1  FIFO accepts a move this cycle.
- `display_out`  out  32  DISPLAY register contents, to the board renderer.

## Operation
Address decode:
- RAM is selected when `address_dmem[31:ADDR_WIDTH]`==0.
- MMIO is selected when `address_dmem[31:0]` is in 0x0000F000..0x0000F004. Registers:
  - 0xF000 STATUS (R): bit0 = not_empty, bit1 = full, bits[7:4] = count (saturating at 15), other bits 0.
  - 0xF001 MOVE_DATA (R): FIFO head zero-extended; reads 0 when empty. Reading does not pop.
  - 0xF002 MOVE_POP (W): pops one entry; the data value is ignored.
  - 0xF003 DISPLAY (R/W): 32-bit register.
  - 0xF004 CYCLE (R): free-running 32-bit counter; wraps at 2^32-1 to 0.
- Any other address reads 0, and writes to it are ignored. Writes to read-only registers are ignored.

Side effects under processor stall:
- The processor holds `address_dmem`/`wren` steady while it stalls.
- Stores are idempotent, except MOVE_POP, which is edge-qualified. A pop fires only on a cycle where (`wren` and addr==0xF002) is 1 and was 0 on the previous cycle.
- Software must separate consecutive pops by at least one non-pop instruction.

FIFO:
- A push occurs when `move_valid` and `move_ready` are both high.
- `move_ready` = !full, taken from registered count with no combinational path from a pop.
- Pop when empty: ignored. Push and pop in the same cycle when empty: push accepted, pop ignored.
- Push and pop in the same cycle when neither full nor empty: both occur, count unchanged.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- `move_data` must be held while `move_valid` is high and `move_ready` is low.

## Timing
- Writes (RAM, DISPLAY, FIFO state, pop edge register) commit on the rising edge of `clock`.
- Reads: `q_dmem` is registered on the falling edge of `clock` from the current address. It is therefore valid before the next rising edge, where the processor captures it.
- Read-after-write:
  - A store at rising edge t is visible to a load issued in the cycle after t.
  - A load in the same cycle as a store to the same address returns the new value, because the falling edge follows the rising edge.
- CYCLE increments every rising edge.
- Reset (asynchronous, mid-operation allowed) sets: `q_dmem`=0, `display_out`=0, CYCLE=0, FIFO empty, `move_ready`=1 once reset is released (0 while asserted), pop edge register=0. RAM contents are not reset.

## Configuration
- `MMIO_MOVE_FIFO_EN` defined: the FIFO, STATUS, MOVE_DATA and MOVE_POP exist as above.
- Undefined: no FIFO storage is built. `move_ready` is tied 0, STATUS and MOVE_DATA read 0, and MOVE_POP writes are ignored. RAM, DISPLAY and CYCLE are unchanged.

## Structure
- Package `dmem_map_pkg`: MMIO address constants (`MMIO_STATUS`, `MMIO_MOVE_DATA`, `MMIO_MOVE_POP`, `MMIO_DISPLAY`, `MMIO_CYCLE`), STATUS bit indices, RAM region mask.
- One sub-module, `move_fifo`: parameterised by depth/width, with valid/ready push, pop strobe, head/count/full/empty outputs, and async active-low reset.

## Test plan
1. sw 0x12345678 to RAM 0x005, then lw 0x005 in the next instruction -> `q_dmem`=0x12345678. lw 0x1000 -> 0.
2. sw 0xABCD0001 to 0xF003 -> `display_out`=0xABCD0001 after that rising edge. lw 0xF003 returns the same value.
3. Push moves 0x0101, 0x0202 -> STATUS=0x21. lw 0xF001 -> 0x0101. sw 0xF002 held for 3 cycles (stall) -> exactly one pop, then lw 0xF001 -> 0x0202.
4. Push 8 moves -> `move_ready`=0, STATUS bit1=1. A 9th push is held until the next pop, then accepted. Pop all -> entries come out in push order across pointer wrap.
5. Assert reset low mid-push with FIFO count 3 and DISPLAY nonzero -> immediately `q_dmem`=0, `display_out`=0, STATUS reads 0 after release, CYCLE restarts at 0.
6. `MMIO_MOVE_FIFO_EN` undefined -> `move_ready`=0 always, lw 0xF000 and lw 0xF001 return 0, RAM and DISPLAY behave as in scenarios 1-2.
